// File: rtl/vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// vga_timing_ctrl
//
// Purpose:
//   Timing sequencer for the VGA pixel path. It divides Clk down to a pixel
//   strobe and runs the horizontal/vertical position counters. It also drives
//   the registered sync pulses and publishes the active-region margins for the
//   current video mode. Mode changes requested while running are held off until
//   the frame wraps, so a frame is never split between two modes.
//
//   Optional feature macro: VGA_FRAME_CNT_EN
//     defined   -> adds output Frame_cnt[7:0], a wrapping count of Frame_start
//     undefined -> no Frame_cnt port or register
//
// Ports:
//   Clk, Rst_n          clock, asynchronous active-low reset
//   Enable              1 = run timing, 0 = idle (blanked, counters at 0)
//   Mode_req, Mode_sel  1-cycle mode change request and the requested mode
//   Mode_ack            1-cycle pulse when the requested mode takes effect
//   Busy                a mode change is pending; further requests ignored
//   Mode_cur            mode currently in effect (0 = 640x480, 1 = 800x600)
//   Pix_en              pixel strobe, one Clk wide
//   Count_h, Count_v    position; 0 = first column/line of the sync pulse
//   H/V_*_margin        first/last active column and line of Mode_cur
//   Hsync, Vsync        sync outputs, polarity depends on the mode
//   Frame_start         pulse on the Pix_en where the counters wrap to (0,0)
// -----------------------------------------------------------------------------
module vga_timing_ctrl #(
    parameter int CNT_WIDTH = 11,
    parameter int PIX_DIV0  = 4,
    parameter int PIX_DIV1  = 2
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Enable,
    input  logic                 Mode_req,
    input  logic                 Mode_sel,
    output logic                 Mode_ack,
    output logic                 Busy,
    output logic                 Mode_cur,
    output logic                 Pix_en,
    output logic [CNT_WIDTH-1:0] Count_h,
    output logic [CNT_WIDTH-1:0] Count_v,
    output logic [CNT_WIDTH-1:0] H_left_margin,
    output logic [CNT_WIDTH-1:0] H_right_margin,
    output logic [CNT_WIDTH-1:0] V_left_margin,
    output logic [CNT_WIDTH-1:0] V_right_margin,
    output logic                 Hsync,
    output logic                 Vsync,
    output logic                 Frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0]           Frame_cnt
`endif
);

    localparam int DIV_W = 8;

    typedef logic [CNT_WIDTH-1:0] cnt_t;
    typedef logic [DIV_W-1:0]     div_t;
    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    // Mode table: index 0 = 640x480@60, index 1 = 800x600@72.
    function automatic cnt_t h_tot(input logic m);
        return m ? cnt_t'(1040) : cnt_t'(800);
    endfunction
    function automatic cnt_t h_sw(input logic m);
        return m ? cnt_t'(120) : cnt_t'(96);
    endfunction
    function automatic cnt_t h_left(input logic m);
        return m ? cnt_t'(184) : cnt_t'(144);
    endfunction
    function automatic cnt_t h_right(input logic m);
        return m ? cnt_t'(983) : cnt_t'(783);
    endfunction
    function automatic cnt_t v_tot(input logic m);
        return m ? cnt_t'(666) : cnt_t'(525);
    endfunction
    function automatic cnt_t v_sw(input logic m);
        return m ? cnt_t'(6) : cnt_t'(2);
    endfunction
    function automatic cnt_t v_left(input logic m);
        return m ? cnt_t'(29) : cnt_t'(35);
    endfunction
    function automatic cnt_t v_right(input logic m);
        return m ? cnt_t'(628) : cnt_t'(514);
    endfunction
    function automatic div_t div_last(input logic m);
        return m ? div_t'(PIX_DIV1 - 1) : div_t'(PIX_DIV0 - 1);
    endfunction

    state_t state_reg, state_next;
    logic   mode_cur_reg, mode_next;
    logic   pend_sel_reg, pend_sel_next;
    div_t   div_reg, div_next;
    cnt_t   count_h_reg, count_h_next;
    cnt_t   count_v_reg, count_v_next;
    logic   pix_en_reg, pix_en_next;
    logic   hsync_reg, hsync_next;
    logic   vsync_reg, vsync_next;
    logic   frame_start_reg, frame_start_next;
    logic   mode_ack_reg, mode_ack_next;
    logic   busy_reg, busy_next;
    cnt_t   h_left_reg, h_right_reg, v_left_reg, v_right_reg;

    logic   tick, last_h, last_v, wrap;

    always_comb begin
        state_next       = state_reg;
        mode_next        = mode_cur_reg;
        pend_sel_next    = pend_sel_reg;
        mode_ack_next    = 1'b0;
        div_next         = '0;
        count_h_next     = '0;
        count_v_next     = '0;
        pix_en_next      = 1'b0;
        frame_start_next = 1'b0;

        tick   = (state_reg != IDLE) && (div_reg == '0);
        last_h = (count_h_reg == h_tot(mode_cur_reg) - cnt_t'(1));
        last_v = (count_v_reg == v_tot(mode_cur_reg) - cnt_t'(1));
        wrap   = tick && last_h && last_v;

        case (state_reg)
            IDLE: begin
                // Nothing is on screen, so a new mode can load immediately.
                if (Mode_req) begin
                    mode_next     = Mode_sel;
                    mode_ack_next = 1'b1;
                end
                if (Enable) state_next = RUN;
            end
            RUN: begin
                if (Mode_req) begin
                    pend_sel_next = Mode_sel;
                    state_next    = PEND;
                end
            end
            PEND: begin
                if (wrap) begin
                    mode_next     = pend_sel_reg;
                    mode_ack_next = 1'b1;
                    state_next    = RUN;
                end
            end
            default: state_next = IDLE;
        endcase

        // Disable wins from any state; a pending mode is applied on the way out.
        if (!Enable) begin
            state_next = IDLE;
            if (state_reg == PEND) begin
                mode_next     = pend_sel_reg;
                mode_ack_next = 1'b1;
            end
        end

        // Counters and divider only move while staying in RUN/PEND; entering
        // or leaving IDLE leaves them at their cleared defaults.
        if (state_next != IDLE && state_reg != IDLE) begin
            pix_en_next = tick;
            div_next    = (div_reg == div_last(mode_cur_reg)) ? '0 : div_reg + div_t'(1);
            count_h_next = count_h_reg;
            count_v_next = count_v_reg;
            if (tick) begin
                count_h_next = last_h ? '0 : count_h_reg + cnt_t'(1);
                if (last_h) count_v_next = last_v ? '0 : count_v_reg + cnt_t'(1);
            end
            frame_start_next = wrap;
        end

        // Syncs follow the next counter values so they line up with Count_*;
        // the mode value doubles as the active level (mode 1 is active-high).
        if (state_next == IDLE) begin
            hsync_next = ~mode_next;
            vsync_next = ~mode_next;
        end else begin
            hsync_next = (count_h_next < h_sw(mode_next)) ? mode_next : ~mode_next;
            vsync_next = (count_v_next < v_sw(mode_next)) ? mode_next : ~mode_next;
        end

        busy_next = (state_next == PEND);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg       <= IDLE;
            mode_cur_reg    <= 1'b0;
            pend_sel_reg    <= 1'b0;
            div_reg         <= '0;
            count_h_reg     <= '0;
            count_v_reg     <= '0;
            pix_en_reg      <= 1'b0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            frame_start_reg <= 1'b0;
            mode_ack_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            h_left_reg      <= h_left(1'b0);
            h_right_reg     <= h_right(1'b0);
            v_left_reg      <= v_left(1'b0);
            v_right_reg     <= v_right(1'b0);
        end else begin
            state_reg       <= state_next;
            mode_cur_reg    <= mode_next;
            pend_sel_reg    <= pend_sel_next;
            div_reg         <= div_next;
            count_h_reg     <= count_h_next;
            count_v_reg     <= count_v_next;
            pix_en_reg      <= pix_en_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            frame_start_reg <= frame_start_next;
            mode_ack_reg    <= mode_ack_next;
            busy_reg        <= busy_next;
            // Mode only changes at a frame wrap or in IDLE, so margins are stable mid-frame.
            h_left_reg      <= h_left(mode_next);
            h_right_reg     <= h_right(mode_next);
            v_left_reg      <= v_left(mode_next);
            v_right_reg     <= v_right(mode_next);
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_reg;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            frame_cnt_reg <= '0;
        end else if (frame_start_next) begin
            frame_cnt_reg <= frame_cnt_reg + 8'd1;
        end
    end

    assign Frame_cnt = frame_cnt_reg;
`endif

    assign Mode_ack       = mode_ack_reg;
    assign Busy           = busy_reg;
    assign Mode_cur       = mode_cur_reg;
    assign Pix_en         = pix_en_reg;
    assign Count_h        = count_h_reg;
    assign Count_v        = count_v_reg;
    assign H_left_margin  = h_left_reg;
    assign H_right_margin = h_right_reg;
    assign V_left_margin  = v_left_reg;
    assign V_right_margin = v_right_reg;
    assign Hsync          = hsync_reg;
    assign Vsync          = vsync_reg;
    assign Frame_start    = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_ctrl
//
// Directed bench for vga_timing_ctrl. Each scenario task drives the DUT and
// compares outputs against values derived from the mode table. Outputs are
// sampled on the falling clock edge. To reach frame ends within a short run,
// the position counters are occasionally jumped ahead with force/release.
// -----------------------------------------------------------------------------
module tb_vga_timing_ctrl;

    localparam int CW = 11;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          Enable;
    logic          Mode_req;
    logic          Mode_sel;
    logic          Mode_ack;
    logic          Busy;
    logic          Mode_cur;
    logic          Pix_en;
    logic [CW-1:0] Count_h;
    logic [CW-1:0] Count_v;
    logic [CW-1:0] H_left_margin;
    logic [CW-1:0] H_right_margin;
    logic [CW-1:0] V_left_margin;
    logic [CW-1:0] V_right_margin;
    logic          Hsync;
    logic          Vsync;
    logic          Frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0]    Frame_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_h;
    int exp_v;
    logic mode_m;
    int ack_total = 0;

    vga_timing_ctrl #(.CNT_WIDTH(CW), .PIX_DIV0(4), .PIX_DIV1(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable),
        .Mode_req(Mode_req), .Mode_sel(Mode_sel), .Mode_ack(Mode_ack),
        .Busy(Busy), .Mode_cur(Mode_cur), .Pix_en(Pix_en),
        .Count_h(Count_h), .Count_v(Count_v),
        .H_left_margin(H_left_margin), .H_right_margin(H_right_margin),
        .V_left_margin(V_left_margin), .V_right_margin(V_right_margin),
        .Hsync(Hsync), .Vsync(Vsync), .Frame_start(Frame_start)
`ifdef VGA_FRAME_CNT_EN
        , .Frame_cnt(Frame_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) if (Mode_ack === 1'b1) ack_total++;

    // Mode table constants (0 = 640x480, 1 = 800x600).
    function automatic int htot(input logic m); return m ? 1040 : 800; endfunction
    function automatic int vtot(input logic m); return m ? 666 : 525; endfunction
    function automatic int hsw(input logic m);  return m ? 120 : 96;   endfunction
    function automatic int vsw(input logic m);  return m ? 6 : 2;      endfunction
    function automatic logic exp_hsync(input logic m, input int h);
        return (h < hsw(m)) ? m : ~m;
    endfunction
    function automatic logic exp_vsync(input logic m, input int v);
        return (v < vsw(m)) ? m : ~m;
    endfunction

    task automatic adv();
        exp_h++;
        if (exp_h == htot(mode_m)) begin
            exp_h = 0;
            exp_v++;
            if (exp_v == vtot(mode_m)) exp_v = 0;
        end
    endtask

    // Wait for the next Pix_en; n = cycles waited, -1 on timeout.
    task automatic next_pix(output int n);
        n = -1;
        for (int i = 1; i <= 64; i++) begin
            @(negedge Clk);
            if (Pix_en === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            checks++; errors++;
            $display("FAIL pix_timeout: Pix_en not seen within 64 cycles");
        end
    endtask

    task automatic jump(input int h, input int v);
        force dut.count_h_reg = CW'(h);
        force dut.count_v_reg = CW'(v);
        #1;
        release dut.count_h_reg;
        release dut.count_v_reg;
        exp_h = h;
        exp_v = v;
    endtask

    task automatic test_reset();
        int n;
        Rst_n = 1'b0; Enable = 1'b1; Mode_req = 1'b0; Mode_sel = 1'b0;
        mode_m = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if ({Pix_en, Mode_ack, Busy, Frame_start, Mode_cur} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {Pix_en, Mode_ack, Busy, Frame_start, Mode_cur});
        end
        checks++;
        if (Count_h !== 0 || Count_v !== 0) begin
            errors++; $display("FAIL reset_counts: got h=%0d v=%0d want 0 0", Count_h, Count_v);
        end
        checks++;
        if (H_left_margin !== 11'd144 || H_right_margin !== 11'd783 ||
            V_left_margin !== 11'd35 || V_right_margin !== 11'd514) begin
            errors++; $display("FAIL reset_margins: got %0d %0d %0d %0d want 144 783 35 514",
                               H_left_margin, H_right_margin, V_left_margin, V_right_margin);
        end
        checks++;
        if ({Hsync, Vsync} !== 2'b11) begin
            errors++; $display("FAIL reset_sync: got %b want 11", {Hsync, Vsync});
        end
        Rst_n = 1'b1;
        @(negedge Clk);  // IDLE -> RUN taken here
        checks++;
        if (Pix_en !== 1'b0 || Count_h !== 0 || Hsync !== 1'b0) begin
            errors++; $display("FAIL run_entry: got pix=%b h=%0d hs=%b want 0 0 0", Pix_en, Count_h, Hsync);
        end
        @(negedge Clk);
        checks++;
        if (Pix_en !== 1'b1 || Count_h !== 11'd1) begin
            errors++; $display("FAIL first_pix: got pix=%b h=%0d want 1 1", Pix_en, Count_h);
        end
        exp_h = 1; exp_v = 0;
        next_pix(n); adv();
        checks++;
        if (n !== 4 || Count_h !== CW'(exp_h)) begin
            errors++; $display("FAIL pix_period0: got n=%0d h=%0d want 4 %0d", n, Count_h, exp_h);
        end
    endtask

    // Three lines of mode 0: period, counters and both syncs on every pixel.
    task automatic test_mode0_sync();
        int n;
        for (int k = 0; k < 2400; k++) begin
            next_pix(n); adv();
            checks++;
            if (n !== 4 || Count_h !== CW'(exp_h) || Count_v !== CW'(exp_v) || Frame_start !== 1'b0) begin
                errors++; $display("FAIL m0_count: got n=%0d h=%0d v=%0d fs=%b want 4 %0d %0d 0",
                                   n, Count_h, Count_v, Frame_start, exp_h, exp_v);
                return;
            end
            checks++;
            if (Hsync !== exp_hsync(1'b0, exp_h) || Vsync !== exp_vsync(1'b0, exp_v)) begin
                errors++; $display("FAIL m0_sync: h=%0d v=%0d got hs=%b vs=%b want %b %b", exp_h, exp_v,
                                   Hsync, Vsync, exp_hsync(1'b0, exp_h), exp_vsync(1'b0, exp_v));
                return;
            end
        end
    endtask

    // Request mode 1 mid-frame, then a second request while busy.
    task automatic test_mode_change();
        int n;
        int ack_base;
        bit seen_wrap;
        ack_base = ack_total;
        jump(exp_h, 100);
        Mode_req = 1'b1; Mode_sel = 1'b1;
        @(negedge Clk);
        Mode_req = 1'b0;
        checks++;
        if (Busy !== 1'b1 || Mode_ack !== 1'b0 || Mode_cur !== 1'b0) begin
            errors++; $display("FAIL req_busy: got busy=%b ack=%b cur=%b want 1 0 0", Busy, Mode_ack, Mode_cur);
        end
        next_pix(n); adv();
        // Back-to-back request while busy must be ignored.
        Mode_req = 1'b1; Mode_sel = 1'b0;
        @(negedge Clk);
        Mode_req = 1'b0;
        checks++;
        if (Busy !== 1'b1 || Mode_ack !== 1'b0) begin
            errors++; $display("FAIL req_ignored: got busy=%b ack=%b want 1 0", Busy, Mode_ack);
        end
        next_pix(n); adv();
        jump(700, 524);
        seen_wrap = 0;
        for (int k = 0; k < 200 && !seen_wrap; k++) begin
            next_pix(n); adv();
            if (exp_h == 0 && exp_v == 0) begin
                seen_wrap = 1;
            end else begin
                checks++;
                if (Busy !== 1'b1 || Mode_cur !== 1'b0 || Frame_start !== 1'b0 || Count_h !== CW'(exp_h)) begin
                    errors++; $display("FAIL pend_hold: got busy=%b cur=%b fs=%b h=%0d want 1 0 0 %0d",
                                       Busy, Mode_cur, Frame_start, Count_h, exp_h);
                    return;
                end
            end
        end
        checks++;
        if (!seen_wrap) begin
            errors++; $display("FAIL frame_end: wrap not reached, h=%0d v=%0d", Count_h, Count_v);
            return;
        end
        checks++;
        if ({Frame_start, Mode_ack, Busy, Mode_cur} !== 4'b1101 || Count_h !== 0 || Count_v !== 0) begin
            errors++; $display("FAIL mode_switch: got fs/ack/busy/cur=%b h=%0d v=%0d want 1101 0 0",
                               {Frame_start, Mode_ack, Busy, Mode_cur}, Count_h, Count_v);
        end
        checks++;
        if (H_left_margin !== 11'd184 || H_right_margin !== 11'd983 ||
            V_left_margin !== 11'd29 || V_right_margin !== 11'd628) begin
            errors++; $display("FAIL m1_margins: got %0d %0d %0d %0d want 184 983 29 628",
                               H_left_margin, H_right_margin, V_left_margin, V_right_margin);
        end
        checks++;
        if ({Hsync, Vsync} !== 2'b11) begin
            errors++; $display("FAIL m1_sync_pol: got %b want 11", {Hsync, Vsync});
        end
        mode_m = 1'b1;
        for (int k = 0; k < 200; k++) begin
            next_pix(n); adv();
            checks++;
            if (n !== 2 || Count_h !== CW'(exp_h) || Count_v !== 0 || Hsync !== exp_hsync(1'b1, exp_h) || Mode_cur !== 1'b1) begin
                errors++; $display("FAIL m1_run: got n=%0d h=%0d v=%0d hs=%b cur=%b want 2 %0d 0 %b 1",
                                   n, Count_h, Count_v, Hsync, Mode_cur, exp_h, exp_hsync(1'b1, exp_h));
                return;
            end
        end
        checks++;
        if (ack_total - ack_base !== 1) begin
            errors++; $display("FAIL ack_once: got %0d acks want 1", ack_total - ack_base);
        end
    endtask

    // Disable with a request pending: mode applies on IDLE entry.
    task automatic test_disable_pending();
        int n;
        Mode_req = 1'b1; Mode_sel = 1'b0;
        @(negedge Clk);
        Mode_req = 1'b0;
        checks++;
        if (Busy !== 1'b1) begin
            errors++; $display("FAIL dis_busy: got busy=%b want 1", Busy);
        end
        next_pix(n);
        Enable = 1'b0;
        @(negedge Clk);
        checks++;
        if ({Mode_ack, Busy, Mode_cur, Pix_en, Frame_start} !== 5'b10000 || Count_h !== 0 || Count_v !== 0) begin
            errors++; $display("FAIL dis_idle: got ack/busy/cur/pix/fs=%b h=%0d v=%0d want 10000 0 0",
                               {Mode_ack, Busy, Mode_cur, Pix_en, Frame_start}, Count_h, Count_v);
        end
        checks++;
        if ({Hsync, Vsync} !== 2'b11 || H_left_margin !== 11'd144) begin
            errors++; $display("FAIL dis_sync: got sync=%b hl=%0d want 11 144", {Hsync, Vsync}, H_left_margin);
        end
        Enable = 1'b1;
        mode_m = 1'b0;
        @(negedge Clk);
        checks++;
        if (Count_h !== 0 || Count_v !== 0 || Pix_en !== 1'b0 || Hsync !== 1'b0 || Vsync !== 1'b0) begin
            errors++; $display("FAIL reen_entry: got h=%0d v=%0d pix=%b hs=%b vs=%b want 0 0 0 0 0",
                               Count_h, Count_v, Pix_en, Hsync, Vsync);
        end
        next_pix(n);
        checks++;
        if (n !== 1 || Count_h !== 11'd1 || Count_v !== 0) begin
            errors++; $display("FAIL reen_first: got n=%0d h=%0d v=%0d want 1 1 0", n, Count_h, Count_v);
        end
        next_pix(n);
        checks++;
        if (n !== 4 || Count_h !== 11'd2) begin
            errors++; $display("FAIL reen_period: got n=%0d h=%0d want 4 2", n, Count_h);
        end
    endtask

    // Mode request in IDLE, then an asynchronous reset in the middle of a line.
    task automatic test_async_reset();
        int n;
        Enable = 1'b0;
        @(negedge Clk);
        Mode_req = 1'b1; Mode_sel = 1'b1;
        @(negedge Clk);
        Mode_req = 1'b0;
        checks++;
        if (Mode_ack !== 1'b1 || Mode_cur !== 1'b1 || Busy !== 1'b0) begin
            errors++; $display("FAIL idle_req: got ack=%b cur=%b busy=%b want 1 1 0", Mode_ack, Mode_cur, Busy);
        end
        @(negedge Clk);
        checks++;
        if (Mode_ack !== 1'b0 || Busy !== 1'b0) begin
            errors++; $display("FAIL idle_ack_pulse: got ack=%b busy=%b want 0 0", Mode_ack, Busy);
        end
        Enable = 1'b1;
        repeat (20) next_pix(n);
        #2;
        Rst_n = 1'b0;
        #1;
        checks++;
        if (Mode_cur !== 1'b0 || Count_h !== 0 || Count_v !== 0 || Pix_en !== 1'b0) begin
            errors++; $display("FAIL async_rst: got cur=%b h=%0d v=%0d pix=%b want 0 0 0 0",
                               Mode_cur, Count_h, Count_v, Pix_en);
        end
        checks++;
        if ({Hsync, Vsync} !== 2'b11 || H_left_margin !== 11'd144 || V_right_margin !== 11'd514) begin
            errors++; $display("FAIL async_rst_out: got sync=%b hl=%0d vr=%0d want 11 144 514",
                               {Hsync, Vsync}, H_left_margin, V_right_margin);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        mode_m = 1'b0;
    endtask

`ifdef VGA_FRAME_CNT_EN
    task automatic test_frame_cnt();
        int n;
        int frames;
        checks++;
        if (Frame_cnt !== 8'd0) begin
            errors++; $display("FAIL fcnt_reset: got %0d want 0", Frame_cnt);
        end
        frames = 0;
        next_pix(n);
        for (int f = 0; f < 3; f++) begin
            jump(790, 524);
            for (int k = 0; k < 40; k++) begin
                next_pix(n);
                if (Frame_start === 1'b1) begin
                    frames++;
                    break;
                end
            end
        end
        repeat (3) @(negedge Clk);
        checks++;
        if (Frame_cnt !== 8'd3 || frames !== 3) begin
            errors++; $display("FAIL fcnt_three: got cnt=%0d frames=%0d want 3 3", Frame_cnt, frames);
        end
    endtask
`endif

    initial begin
        test_reset();
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
        test_mode0_sync();
        $display("test_mode0_sync done: checks=%0d errors=%0d", checks, errors);
        test_mode_change();
        $display("test_mode_change done: checks=%0d errors=%0d", checks, errors);
        test_disable_pending();
        $display("test_disable_pending done: checks=%0d errors=%0d", checks, errors);
        test_async_reset();
        $display("test_async_reset done: checks=%0d errors=%0d", checks, errors);
`ifdef VGA_FRAME_CNT_EN
        test_frame_cnt();
        $display("test_frame_cnt done: checks=%0d errors=%0d", checks, errors);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
